regfile_wb_buffer: RTL

//  Write-back buffer feeding the 16x16 register file write port (write/address/data).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/wb_fifo.sv | 57 +++++
 rtl/regfile_wb_buffer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types: widths, register count and the write-back entry layout.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back queue: storage, head/tail/count, and per-entry occupancy and age
// (age 0 = most recently pushed) so the bypass can pick the youngest match.
module wb_fifo
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  regfile_pkg::wb_entry_t push_entry,
    input  logic                  pop,
    output regfile_pkg::wb_entry_t head_entry,
    output regfile_pkg::wb_entry_t entries [DEPTH],
    output logic [DEPTH-1:0]      occupied,
    output logic [PTR_W-1:0]      age [DEPTH],
    output logic [PTR_W:0]        count
);
    import regfile_pkg::*;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payloads carry no control meaning, so they are left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_entry;
    end

    assign head_entry = mem[head];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i]  = mem[i];
            age[i]      = tail - PTR_W'(1) - PTR_W'(i);
            occupied[i] = ((PTR_W+1)'(age[i]) < count);
        end
    end

endmodule

// File: rtl/regfile_wb_buffer.sv
// Write-back buffer in front of the register-file write port: handshake, registered
// write stage, two youngest-first bypass lookups and a drain sequencer.
module regfile_wb_buffer
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DEPTH  = 4
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     rf_hold,
    input  logic                     drain,
    output logic                     drain_done,
    output logic                     write,
    output logic [ADDR_W-1:0]        address,
    output logic [DATA_W-1:0]        data,
    input  logic [ADDR_W-1:0]        byp_addr1,
    input  logic [ADDR_W-1:0]        byp_addr2,
    output logic                     byp_hit1,
    output logic [DATA_W-1:0]        byp_data1,
    output logic                     byp_hit2,
    output logic [DATA_W-1:0]        byp_data2,
    output logic [$clog2(DEPTH):0]   count
);
    import regfile_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             push;
    logic             pop;
    wb_entry_t        push_entry;
    wb_entry_t        head_entry;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] occupied;
    logic [PTR_W-1:0] age [DEPTH];

    // No pass-through when full: acceptance depends only on current occupancy.
    assign in_ready   = (state == RUN) && (count < (PTR_W+1)'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (count != '0) && !rf_hold;
    assign push_entry = '{addr: in_addr, data: in_data};

    wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .entries    (entries),
        .occupied   (occupied),
        .age        (age),
        .count      (count)
    );

    // Output stage: address/data hold their last value when nothing retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write   <= 1'b0;
            address <= '0;
            data    <= '0;
        end else begin
            write <= pop;
            if (pop) begin
                address <= head_entry.addr;
                data    <= head_entry.data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (drain) state_nxt = DRAIN;
            DRAIN:   if ((count == '0) && !write) state_nxt = DONE;
            DONE:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign drain_done = (state == DONE);

    // Youngest queued match wins; the output stage only answers when no queue entry does.
    always_comb begin
        logic [PTR_W-1:0] best1;
        logic [PTR_W-1:0] best2;
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        best1     = '0;
        best2     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && (entries[i].addr == byp_addr1) && (!byp_hit1 || (age[i] < best1))) begin
                byp_hit1  = 1'b1;
                best1     = age[i];
                byp_data1 = entries[i].data;
            end
            if (occupied[i] && (entries[i].addr == byp_addr2) && (!byp_hit2 || (age[i] < best2))) begin
                byp_hit2  = 1'b1;
                best2     = age[i];
                byp_data2 = entries[i].data;
            end
        end
        if (!byp_hit1 && write && (address == byp_addr1)) begin
            byp_hit1  = 1'b1;
            byp_data1 = data;
        end
        if (!byp_hit2 && write && (address == byp_addr2)) begin
            byp_hit2  = 1'b1;
            byp_data2 = data;
        end
    end

endmodule
